// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, load extraction, writeback mux and the
// retired-instruction counter feeding the decode-stage register file.
package writeback_pkg;
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;
endpackage

module writeback_stage
  import writeback_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic                     MEM_valid_i,
  input  logic [DATA_WIDTH-1:0]    MEM_instruction_i,
  input  logic                     MEM_RegWrite_i,
  input  wb_sel_e                  MEM_WBSel_i,
  input  logic [DATA_WIDTH-1:0]    MEM_alu_result_i,
  input  logic [DATA_WIDTH-1:0]    MEM_rd_data_i,
  input  logic [DATA_WIDTH-1:0]    MEM_pc_plus4_i,
  output logic                     WB_valid_o,
  output logic                     WB_we_o,
  output logic [ADDR_WIDTH-1:0]    WB_wr_addr_o,
  output logic [DATA_WIDTH-1:0]    WB_wr_data_o,
  output logic [INSTRET_WIDTH-1:0] WB_instret_o
);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic                     valid_q;
  logic                     reg_write_q;
  wb_sel_e                  wb_sel_q;
  logic [DATA_WIDTH-1:0]    instr_q;
  logic [DATA_WIDTH-1:0]    alu_q;
  logic [DATA_WIDTH-1:0]    rd_data_q;
  logic [DATA_WIDTH-1:0]    pc4_q;
  logic [INSTRET_WIDTH-1:0] instret_q;

  logic [ADDR_WIDTH-1:0]    rd;
  logic [2:0]               funct3;
  logic [1:0]               off;
  logic [7:0]               ld_byte;
  logic [15:0]              ld_half;
  logic [DATA_WIDTH-1:0]    load_val;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     instr_unused;

  // stall_i holds every field and suppresses retire; flush_i loads a bubble only
  // when not stalled, so a stalled flush is dropped and must be re-asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      instr_q     <= NOP;
      reg_write_q <= 1'b0;
      wb_sel_q    <= WB_ALU;
      alu_q       <= '0;
      rd_data_q   <= '0;
      pc4_q       <= '0;
      instret_q   <= '0;
    end else if (!stall_i) begin
      if (flush_i) begin
        valid_q     <= 1'b0;
        instr_q     <= '0;
        reg_write_q <= 1'b0;
        wb_sel_q    <= WB_ALU;
        alu_q       <= '0;
        rd_data_q   <= '0;
        pc4_q       <= '0;
      end else begin
        valid_q     <= MEM_valid_i;
        instr_q     <= MEM_instruction_i;
        reg_write_q <= MEM_RegWrite_i;
        wb_sel_q    <= MEM_WBSel_i;
        alu_q       <= MEM_alu_result_i;
        rd_data_q   <= MEM_rd_data_i;
        pc4_q       <= MEM_pc_plus4_i;
      end
      // The resident instruction retires on this edge even if a bubble replaces it.
      if (valid_q) instret_q <= instret_q + INSTRET_WIDTH'(1);
    end
  end

  assign rd           = instr_q[7 +: ADDR_WIDTH];
  assign funct3       = instr_q[14:12];
  assign off          = alu_q[1:0];
  assign instr_unused = ^{instr_q[DATA_WIDTH-1:15], instr_q[6:0]};

  // Little-endian lane select; off[0] is ignored for halves.
  always_comb begin
    ld_byte = rd_data_q[7:0];
    case (off)
      2'd0: ld_byte = rd_data_q[7:0];
      2'd1: ld_byte = rd_data_q[15:8];
      2'd2: ld_byte = rd_data_q[23:16];
      2'd3: ld_byte = rd_data_q[31:24];
      default: ld_byte = rd_data_q[7:0];
    endcase
    ld_half = off[1] ? rd_data_q[31:16] : rd_data_q[15:0];
    case (funct3)
      3'b000:  load_val = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_val = DATA_WIDTH'(ld_byte);
      3'b001:  load_val = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  load_val = DATA_WIDTH'(ld_half);
      default: load_val = rd_data_q;
    endcase
  end

  always_comb begin
    case (wb_sel_q)
      WB_ALU:  wr_data = alu_q;
      WB_MEM:  wr_data = load_val;
      WB_PC4:  wr_data = pc4_q;
      default: wr_data = '0;
    endcase
  end

  assign WB_valid_o   = valid_q;
  assign WB_we_o      = valid_q & reg_write_q & (rd != '0) & ~stall_i;
  assign WB_wr_addr_o = valid_q ? rd : '0;
  assign WB_wr_data_o = wr_data;
  assign WB_instret_o = instret_q;
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Holds the MEM/WB pipeline register and produces the register-file write triple (WB_we_o, WB_wr_addr_o, WB_wr_data_o) consumed by the decode stage's register file.
- Performs load-data extraction (byte/half/word, signed/unsigned) and selects writeback data by WBSel.
- Maintains the 64-bit retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, datapath width (from defines).
- ADDR_WIDTH, 5, register address width (from defines).
- INSTRET_WIDTH, 64, retired-instruction counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  hold MEM/WB register; no retire this cycle.
- flush_i  input  1  load a bubble instead of MEM inputs (effective only when stall_i=0).
- MEM_valid_i  input  1  MEM stage holds a real instruction.
- MEM_instruction_i  input  DATA_WIDTH  instruction word (rd=[11:7], funct3=[14:12]).
- MEM_RegWrite_i  input  1  instruction writes rd.
- MEM_WBSel_i  input  wb_sel_e  writeback source: WB_ALU, WB_MEM, WB_PC4.
- MEM_alu_result_i  input  DATA_WIDTH  ALU result / load effective address.
- MEM_rd_data_i  input  DATA_WIDTH  raw 32-bit word read from data memory.
- MEM_pc_plus4_i  input  DATA_WIDTH  PC+4 for JAL/JALR.
- WB_valid_o  output  1  register holds a real instruction.
- WB_we_o  output  1  register-file write enable.
- WB_wr_addr_o  output  ADDR_WIDTH  destination register.
- WB_wr_data_o  output  DATA_WIDTH  write data.
- WB_instret_o  output  INSTRET_WIDTH  retired-instruction count.

Behaviour:
- Reset is synchronous, active-high, and the clock is one domain. On rst=1 at a rising edge:
  - MEM/WB register cleared: valid=0, instruction=0x00000013 (NOP), RegWrite=0, WBSel=WB_ALU, data fields=0.
  - Counter cleared to 0.
  - Outputs after reset: WB_valid_o=0, WB_we_o=0, WB_wr_addr_o=0, WB_wr_data_o=0, WB_instret_o=0.
- Reset mid-stall or mid-flush: reset wins over both.
- Register update priority per rising edge: rst > stall_i (hold all fields) > flush_i (valid=0, RegWrite=0, others don't-care but zeroed) > capture all MEM_* inputs.
- stall_i=1 with flush_i=1: register holds and flush is ignored. The controller must re-assert flush after the stall.
- Latency: 1 cycle. An instruction presented on MEM_* at edge N drives WB_* outputs combinationally from edge N until the register advances.
- WB_we_o = valid & RegWrite & (rd!=0) & !stall_i. Writes to x0 are never issued, and no write occurs while stalled.
- WB_wr_addr_o = rd field of the registered instruction whenever valid=1, else 0.
- WB_wr_data_o by WBSel:
  - WB_ALU: alu_result.
  - WB_PC4: pc_plus4.
  - WB_MEM: extracted load value.
  - Any other enum value: 0.
- Load extraction uses off = alu_result[1:0] and funct3:
  - 000 LB: byte[off], sign-extended.
  - 100 LBU: byte[off], zero-extended.
  - 001 LH: half[off[1]], sign-extended. off[0] is ignored (misalignment is trapped upstream).
  - 101 LHU: half[off[1]], zero-extended.
  - 010 LW: full word; off ignored.
  - Other funct3: full word.
  - Byte/half ordering is little-endian: byte0=[7:0], half1=[31:16].
- Counter: increments by 1 on each rising edge where valid=1, stall_i=0, rst=0.
  - Bubbles, stalled cycles and flushed slots never count.
  - Wraps from all-ones to 0 silently.
  - The resident instruction retires on the same edge a flush loads a bubble.
- WB_wr_data_o is driven even when WB_we_o=0; consumers must qualify it with WB_we_o.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random MEM_* inputs -> all outputs 0, WB_instret_o=0; first valid ADDI x5 (alu_result=0x0000002A) after release -> WB_we_o=1, addr=5, data=0x2A, instret=1 one edge later.
- Loads: MEM_rd_data_i=0x80FF7F01. LB at off=1 -> 0x0000007F; LB at off=2 -> 0xFFFFFFFF; LBU at off=3 -> 0x00000080; LH at off=2 -> 0xFFFF80FF; LHU at off=0 -> 0x00007F01; LW -> 0x80FF7F01.
- x0 and PC4: JAL with rd=x0 -> WB_we_o=0 but valid=1 and instret increments. JAL rd=x1, pc_plus4=0x00000104 -> we=1, addr=1, data=0x104.
- Stall: valid ADD resident, stall_i=1 for 3 cycles -> WB_we_o=0 and outputs/instret frozen. Stall release -> we=1 for one cycle, instret +1 exactly once.
- Flush: flush_i=1 with a valid MEM instruction -> next cycle WB_valid_o=0, WB_we_o=0, instret unchanged. flush_i=1 together with stall_i=1 -> register unchanged.
- Wrap: force counter to 0xFFFFFFFF_FFFFFFFF, retire one instruction -> WB_instret_o=0.
